// File: rtl/pipeline_stall_control.sv
// rtl/pipeline_stall_control.sv - pipeline stall/flush controller with memory watchdog and performance counters
module pipeline_stall_control #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             Ctrl_Sel,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] memwait_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             error
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic             flush_pend_q, flush_pend_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] stall_cnt_q, memwait_cnt_q, flush_cnt_q;

    logic mem_stall;
    logic wd_hit;
    logic halted;

    assign mem_stall = icache_stall | dcache_stall;
    assign halted    = (state_q == HALT);
    // This stall cycle is the TIMEOUT-th consecutive one
    assign wd_hit    = mem_stall && (wd_q == WD_W'(TIMEOUT - 1));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // State, pending flush, watchdog and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
            wd_q         <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            wd_q         <= wd_d;
            error_q      <= error_d;
        end
    end

    // Next-state: memory stalls dominate, watchdog escalates to HALT, HALT is terminal
    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        wd_d         = wd_q;
        error_d      = error_q;
        if (!halted) begin
            if (mem_stall) begin
                wd_d    = wd_hit ? wd_q : wd_q + WD_W'(1);
                state_d = wd_hit ? HALT : MEM_WAIT;
                error_d = error_q | wd_hit;
                if (branch_taken) begin
                    flush_pend_d = 1'b1;
                end
            end else begin
                wd_d    = '0;
                state_d = RUN;
                // Without a hazard the pending flush (if any) is issued this cycle
                if (!hazard_stall) begin
                    flush_pend_d = 1'b0;
                end
            end
        end
    end

    // Outputs: reset and HALT freeze everything, then mem stall, hazard bubble, flush, run
    always_comb begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        IF_ID_Flush  = 1'b0;
        Ctrl_Sel     = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
        MEM_WB_Write = 1'b0;
        if (!rst && !halted) begin
            if (mem_stall) begin
                Ctrl_Sel = 1'b1;
            end else if (hazard_stall) begin
                ID_EX_Write  = 1'b1;
                EX_MEM_Write = 1'b1;
                MEM_WB_Write = 1'b1;
            end else begin
                PCWrite      = 1'b1;
                IF_ID_Write  = 1'b1;
                Ctrl_Sel     = 1'b1;
                ID_EX_Write  = 1'b1;
                EX_MEM_Write = 1'b1;
                MEM_WB_Write = 1'b1;
                IF_ID_Flush  = branch_taken | flush_pend_q;
            end
        end
    end

    // Saturating performance counters; frozen once halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            memwait_cnt_q <= '0;
            flush_cnt_q   <= '0;
        end else if (!halted) begin
            if (!mem_stall && hazard_stall) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (mem_stall) begin
                memwait_cnt_q <= sat_inc(memwait_cnt_q);
            end
            if (IF_ID_Flush) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign memwait_cnt = memwait_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign error       = error_q;

endmodule
